// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and state type for the fetch stage
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_4180;
  localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;

  typedef enum logic {RUN = 1'b0, WAIT = 1'b1} fetch_state_t;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with load, bubble and valid-clear controls
module if_id_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        bubble,
  input  logic        clear,
  input  logic [31:0] next_instr,
  input  logic [31:0] next_pc,
  input  logic        next_adel,
  input  logic        next_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc8,
  output logic        valid,
  output logic        adel
);

  // clear outranks load: an exception or a squash during stall kills the slot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr <= NOP_INSTR;
      pc    <= RESET_PC;
      pc8   <= RESET_PC + 32'd8;
      valid <= 1'b0;
      adel  <= 1'b0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      instr <= next_instr;
      pc    <= next_pc;
      pc8   <= next_pc + 32'd8;
      valid <= next_valid;
      adel  <= next_adel;
    end else if (bubble) begin
      valid <= 1'b0;
      adel  <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - fetch PC, next-PC select and IF/ID register; FETCH_PERF_CNT_EN adds perf counters
module fetch_pc_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] npc_F,
  output logic [31:0] pc,
  output logic        imem_req,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall_D,
  input  logic        flush_D,
  input  logic        redirect_v,
  input  logic [31:0] redirect_pc,
  input  logic        exc_req,
  output logic [31:0] instr_D,
  output logic [31:0] pc_D,
  output logic [31:0] pc8_D,
  output logic        valid_D,
  output logic        adel_D
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_miss_cnt
`endif
);

  fetch_state_t state;
  logic         pend_v;
  logic [31:0]  pend_pc;
  logic         mis;
  logic         rdy;
  logic         adv;

  // a misaligned PC never goes to memory; it completes at once as an AdEL slot
  assign mis      = (pc[1:0] != 2'b00);
  assign imem_req = !mis;
  assign rdy      = imem_ready | mis;
  assign adv      = rdy & !stall_D;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc      <= RESET_PC;
      state   <= RUN;
      pend_v  <= 1'b0;
      pend_pc <= 32'h0;
    end else if (exc_req) begin
      pc     <= EXC_VECTOR;
      pend_v <= 1'b0;
      state  <= RUN;
    end else begin
      if (state == RUN) begin
        if (imem_req && !imem_ready) state <= WAIT;
      end else if (imem_ready) begin
        state <= RUN;
      end
      // a redirect seen while the delay slot is still in flight is parked in pend
      if (adv) begin
        if (pend_v) begin
          pc     <= pend_pc;
          pend_v <= 1'b0;
        end else if (redirect_v) begin
          pc <= redirect_pc;
        end else begin
          pc <= npc_F;
        end
      end else if (redirect_v) begin
        pend_v  <= 1'b1;
        pend_pc <= redirect_pc;
      end
    end
  end

  if_id_reg #(
    .RESET_PC (RESET_PC)
  ) u_if_id (
    .clk        (clk),
    .reset      (reset),
    .load       (adv & !exc_req),
    .bubble     (!stall_D & !rdy),
    .clear      (exc_req | (stall_D & flush_D)),
    .next_instr (mis ? NOP_INSTR : imem_rdata),
    .next_pc    (pc),
    .next_adel  (mis),
    .next_valid (!flush_D),
    .instr      (instr_D),
    .pc         (pc_D),
    .pc8        (pc8_D),
    .valid      (valid_D),
    .adel       (adel_D)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetch_cnt <= 32'h0;
      perf_miss_cnt  <= 32'h0;
    end else begin
      if (adv && !exc_req && !flush_D) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (state == WAIT) perf_miss_cnt <= perf_miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb/tb_fetch_pc_unit.sv - directed bench for fetch_pc_unit; FETCH_PERF_CNT_EN checks the counters
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] npc_F;
  logic [31:0] pc;
  logic        imem_req;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall_D;
  logic        flush_D;
  logic        redirect_v;
  logic [31:0] redirect_pc;
  logic        exc_req;
  logic [31:0] instr_D;
  logic [31:0] pc_D;
  logic [31:0] pc8_D;
  logic        valid_D;
  logic        adel_D;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_miss_cnt;
`endif

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  // NPC adder and instruction memory: each word encodes its own address
  assign npc_F      = pc + 32'd4;
  assign imem_rdata = {16'hC0DE, pc[15:0]};

  fetch_pc_unit dut (
    .clk         (clk),
    .reset       (reset),
    .npc_F       (npc_F),
    .pc          (pc),
    .imem_req    (imem_req),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .stall_D     (stall_D),
    .flush_D     (flush_D),
    .redirect_v  (redirect_v),
    .redirect_pc (redirect_pc),
    .exc_req     (exc_req),
    .instr_D     (instr_D),
    .pc_D        (pc_D),
    .pc8_D       (pc8_D),
    .valid_D     (valid_D),
    .adel_D      (adel_D)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_miss_cnt  (perf_miss_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vecs++; if (pc !== 32'h3000) begin errs++; $display("FAIL rst_pc got=%h exp=%h", pc, 32'h3000); end
    vecs++; if (imem_req !== 1'b1) begin errs++; $display("FAIL rst_req got=%b exp=1", imem_req); end
    vecs++; if (valid_D !== 1'b0) begin errs++; $display("FAIL rst_valid got=%b exp=0", valid_D); end
    vecs++; if (pc_D !== 32'h3000) begin errs++; $display("FAIL rst_pc_D got=%h exp=%h", pc_D, 32'h3000); end
    vecs++; if (pc8_D !== 32'h3008) begin errs++; $display("FAIL rst_pc8_D got=%h exp=%h", pc8_D, 32'h3008); end
    vecs++; if (instr_D !== 32'h0) begin errs++; $display("FAIL rst_instr got=%h exp=0", instr_D); end
    vecs++; if (adel_D !== 1'b0) begin errs++; $display("FAIL rst_adel got=%b exp=0", adel_D); end
    reset = 1'b1;
  endtask

  task automatic test_sequential();
    step();
    vecs++; if (pc !== 32'h3004) begin errs++; $display("FAIL seq_pc0 got=%h exp=%h", pc, 32'h3004); end
    vecs++; if (pc_D !== 32'h3000) begin errs++; $display("FAIL seq_pc_D0 got=%h exp=%h", pc_D, 32'h3000); end
    vecs++; if (pc8_D !== 32'h3008) begin errs++; $display("FAIL seq_pc8_D0 got=%h exp=%h", pc8_D, 32'h3008); end
    vecs++; if (valid_D !== 1'b1) begin errs++; $display("FAIL seq_valid0 got=%b exp=1", valid_D); end
    vecs++; if (instr_D !== 32'hC0DE3000) begin errs++; $display("FAIL seq_instr0 got=%h exp=%h", instr_D, 32'hC0DE3000); end
    step();
    vecs++; if (pc !== 32'h3008) begin errs++; $display("FAIL seq_pc1 got=%h exp=%h", pc, 32'h3008); end
    vecs++; if (pc_D !== 32'h3004) begin errs++; $display("FAIL seq_pc_D1 got=%h exp=%h", pc_D, 32'h3004); end
    vecs++; if (pc8_D !== 32'h300C) begin errs++; $display("FAIL seq_pc8_D1 got=%h exp=%h", pc8_D, 32'h300C); end
  endtask

  task automatic test_imem_wait();
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vecs++; if (pc !== 32'h3008) begin errs++; $display("FAIL wait_pc[%0d] got=%h exp=%h", i, pc, 32'h3008); end
      vecs++; if (valid_D !== 1'b0) begin errs++; $display("FAIL wait_valid[%0d] got=%b exp=0", i, valid_D); end
    end
    imem_ready = 1'b1;
    step();
    vecs++; if (pc !== 32'h300C) begin errs++; $display("FAIL wait_pc_end got=%h exp=%h", pc, 32'h300C); end
    vecs++; if (pc_D !== 32'h3008) begin errs++; $display("FAIL wait_pc_D got=%h exp=%h", pc_D, 32'h3008); end
    vecs++; if (instr_D !== 32'hC0DE3008) begin errs++; $display("FAIL wait_instr got=%h exp=%h", instr_D, 32'hC0DE3008); end
    vecs++; if (valid_D !== 1'b1) begin errs++; $display("FAIL wait_valid_end got=%b exp=1", valid_D); end
  endtask

  task automatic test_pending_redirect();
    imem_ready  = 1'b0;
    redirect_v  = 1'b1;
    redirect_pc = 32'h3100;
    step();
    vecs++; if (pc !== 32'h300C) begin errs++; $display("FAIL pend_hold_pc got=%h exp=%h", pc, 32'h300C); end
    vecs++; if (valid_D !== 1'b0) begin errs++; $display("FAIL pend_bubble got=%b exp=0", valid_D); end
    redirect_v = 1'b0;
    imem_ready = 1'b1;
    step();
    vecs++; if (pc !== 32'h3100) begin errs++; $display("FAIL pend_target got=%h exp=%h", pc, 32'h3100); end
    vecs++; if (pc_D !== 32'h300C) begin errs++; $display("FAIL pend_slot_pc got=%h exp=%h", pc_D, 32'h300C); end
    vecs++; if (instr_D !== 32'hC0DE300C) begin errs++; $display("FAIL pend_slot_instr got=%h exp=%h", instr_D, 32'hC0DE300C); end
    vecs++; if (pc8_D !== 32'h3014) begin errs++; $display("FAIL pend_slot_pc8 got=%h exp=%h", pc8_D, 32'h3014); end
    vecs++; if (valid_D !== 1'b1) begin errs++; $display("FAIL pend_slot_valid got=%b exp=1", valid_D); end
  endtask

  task automatic test_exc_stall();
    imem_ready  = 1'b0;
    stall_D     = 1'b1;
    redirect_v  = 1'b1;
    redirect_pc = 32'h3200;
    step();
    vecs++; if (pc !== 32'h3100) begin errs++; $display("FAIL exc_pre_pc got=%h exp=%h", pc, 32'h3100); end
    vecs++; if (valid_D !== 1'b1) begin errs++; $display("FAIL exc_stall_valid got=%b exp=1", valid_D); end
    vecs++; if (pc_D !== 32'h300C) begin errs++; $display("FAIL exc_stall_pc_D got=%h exp=%h", pc_D, 32'h300C); end
    exc_req    = 1'b1;
    redirect_v = 1'b0;
    step();
    vecs++; if (pc !== 32'h4180) begin errs++; $display("FAIL exc_vector got=%h exp=%h", pc, 32'h4180); end
    vecs++; if (valid_D !== 1'b0) begin errs++; $display("FAIL exc_valid got=%b exp=0", valid_D); end
    exc_req    = 1'b0;
    stall_D    = 1'b0;
    imem_ready = 1'b1;
    step();
    vecs++; if (pc !== 32'h4184) begin errs++; $display("FAIL exc_pend_drop got=%h exp=%h", pc, 32'h4184); end
    vecs++; if (pc_D !== 32'h4180) begin errs++; $display("FAIL exc_pc_D got=%h exp=%h", pc_D, 32'h4180); end
    vecs++; if (valid_D !== 1'b1) begin errs++; $display("FAIL exc_valid_after got=%b exp=1", valid_D); end
  endtask

  task automatic test_misaligned();
    redirect_v  = 1'b1;
    redirect_pc = 32'h3102;
    step();
    vecs++; if (pc !== 32'h3102) begin errs++; $display("FAIL mis_pc got=%h exp=%h", pc, 32'h3102); end
    vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL mis_req got=%b exp=0", imem_req); end
    redirect_v = 1'b0;
    imem_ready = 1'b0;
    step();
    vecs++; if (pc !== 32'h3106) begin errs++; $display("FAIL mis_adv_pc got=%h exp=%h", pc, 32'h3106); end
    vecs++; if (adel_D !== 1'b1) begin errs++; $display("FAIL mis_adel got=%b exp=1", adel_D); end
    vecs++; if (instr_D !== 32'h0) begin errs++; $display("FAIL mis_instr got=%h exp=0", instr_D); end
    vecs++; if (pc_D !== 32'h3102) begin errs++; $display("FAIL mis_pc_D got=%h exp=%h", pc_D, 32'h3102); end
    vecs++; if (pc8_D !== 32'h310A) begin errs++; $display("FAIL mis_pc8_D got=%h exp=%h", pc8_D, 32'h310A); end
    vecs++; if (valid_D !== 1'b1) begin errs++; $display("FAIL mis_valid got=%b exp=1", valid_D); end
  endtask

  task automatic test_wrap();
    imem_ready  = 1'b1;
    redirect_v  = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    vecs++; if (pc !== 32'hFFFF_FFFC) begin errs++; $display("FAIL wrap_pc0 got=%h exp=%h", pc, 32'hFFFF_FFFC); end
    redirect_v = 1'b0;
    step();
    vecs++; if (pc !== 32'h0) begin errs++; $display("FAIL wrap_pc got=%h exp=0", pc); end
    vecs++; if (pc_D !== 32'hFFFF_FFFC) begin errs++; $display("FAIL wrap_pc_D got=%h exp=%h", pc_D, 32'hFFFF_FFFC); end
    vecs++; if (pc8_D !== 32'h4) begin errs++; $display("FAIL wrap_pc8_D got=%h exp=4", pc8_D); end
    vecs++; if (instr_D !== 32'hC0DEFFFC) begin errs++; $display("FAIL wrap_instr got=%h exp=%h", instr_D, 32'hC0DEFFFC); end
    vecs++; if (adel_D !== 1'b0) begin errs++; $display("FAIL wrap_adel got=%b exp=0", adel_D); end
  endtask

  task automatic test_flush_stall();
    flush_D = 1'b1;
    step();
    vecs++; if (pc !== 32'h4) begin errs++; $display("FAIL flush_pc got=%h exp=4", pc); end
    vecs++; if (valid_D !== 1'b0) begin errs++; $display("FAIL flush_valid got=%b exp=0", valid_D); end
    vecs++; if (pc_D !== 32'h0) begin errs++; $display("FAIL flush_pc_D got=%h exp=0", pc_D); end
    flush_D = 1'b0;
    stall_D = 1'b1;
    step();
    vecs++; if (pc !== 32'h4) begin errs++; $display("FAIL stall_pc got=%h exp=4", pc); end
    vecs++; if (pc_D !== 32'h0) begin errs++; $display("FAIL stall_pc_D got=%h exp=0", pc_D); end
    stall_D = 1'b0;
    step();
    vecs++; if (pc !== 32'h8) begin errs++; $display("FAIL unstall_pc got=%h exp=8", pc); end
    vecs++; if (valid_D !== 1'b1) begin errs++; $display("FAIL unstall_valid got=%b exp=1", valid_D); end
    stall_D = 1'b1;
    flush_D = 1'b1;
    step();
    vecs++; if (pc !== 32'h8) begin errs++; $display("FAIL stflush_pc got=%h exp=8", pc); end
    vecs++; if (valid_D !== 1'b0) begin errs++; $display("FAIL stflush_valid got=%b exp=0", valid_D); end
    vecs++; if (pc_D !== 32'h4) begin errs++; $display("FAIL stflush_pc_D got=%h exp=4", pc_D); end
    stall_D = 1'b0;
    flush_D = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    redirect_v  = 1'b1;
    redirect_pc = 32'h3010;
    step();
    vecs++; if (pc !== 32'h3010) begin errs++; $display("FAIL rw_pc got=%h exp=%h", pc, 32'h3010); end
    redirect_v = 1'b0;
    imem_ready = 1'b0;
    step();
    step();
    vecs++; if (pc !== 32'h3010) begin errs++; $display("FAIL rw_wait_pc got=%h exp=%h", pc, 32'h3010); end
`ifdef FETCH_PERF_CNT_EN
    vecs++; if (perf_miss_cnt === 32'h0) begin errs++; $display("FAIL rw_miss_pre got=%h exp=nonzero", perf_miss_cnt); end
`endif
    #2;
    reset = 1'b0;
    #1;
    vecs++; if (pc !== 32'h3000) begin errs++; $display("FAIL rw_pc_rst got=%h exp=%h", pc, 32'h3000); end
    vecs++; if (valid_D !== 1'b0) begin errs++; $display("FAIL rw_valid got=%b exp=0", valid_D); end
    vecs++; if (pc_D !== 32'h3000) begin errs++; $display("FAIL rw_pc_D got=%h exp=%h", pc_D, 32'h3000); end
    vecs++; if (imem_req !== 1'b1) begin errs++; $display("FAIL rw_req got=%b exp=1", imem_req); end
`ifdef FETCH_PERF_CNT_EN
    vecs++; if (perf_fetch_cnt !== 32'h0) begin errs++; $display("FAIL rw_fetch_cnt got=%h exp=0", perf_fetch_cnt); end
    vecs++; if (perf_miss_cnt !== 32'h0) begin errs++; $display("FAIL rw_miss_cnt got=%h exp=0", perf_miss_cnt); end
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL timeout pc=%h", pc);
    $fatal(1);
  end

  initial begin
    reset       = 1'b0;
    imem_ready  = 1'b1;
    stall_D     = 1'b0;
    flush_D     = 1'b0;
    redirect_v  = 1'b0;
    redirect_pc = 32'h0;
    exc_req     = 1'b0;
    step();
    step();
    test_reset();
    test_sequential();
    test_imem_wait();
    test_pending_redirect();
    test_exc_stall();
    test_misaligned();
    test_wrap();
    test_flush_stall();
    test_reset_in_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Fetch-stage PC register and IF/ID pipeline register for the 5-stage MIPS core.
- Holds the current PC, drives it to the NPC incrementer and to instruction memory, and selects the next PC from npc_F, an ID-stage branch/jump redirect, or an exception redirect.
- Absorbs variable-latency instruction memory through a ready handshake and delivers instr_D, pc_D, pc8_D and valid_D to decode.
- Honours the MIPS branch delay slot.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_4180, PC value loaded on an exception redirect.

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- npc_F  input  32  sequential next PC (pc+4) from NPC.
- pc  output  32  current fetch PC; also drives the instruction memory address.
- imem_req  output  1  fetch request; 0 when the PC is misaligned.
- imem_ready  input  1  imem_rdata is valid for pc in this cycle.
- imem_rdata  input  32  fetched instruction word.
- stall_D  input  1  hazard unit holds IF and ID.
- flush_D  input  1  squash the instruction entering ID.
- redirect_v  input  1  branch/jump taken, resolved in ID.
- redirect_pc  input  32  branch/jump target.
- exc_req  input  1  exception/eret redirect from a later stage.
- instr_D  output  32  IF/ID instruction.
- pc_D  output  32  PC of instr_D.
- pc8_D  output  32  pc_D+8, the link address.
- valid_D  output  1  instr_D is a real instruction.
- adel_D  output  1  instr_D came from a misaligned PC (AdEL).

Behaviour:
- Reset (reset==0, asynchronous):
  - pc=RESET_PC, state=RUN, pend_v=0, pend_pc=0.
  - instr_D=0, pc_D=RESET_PC, pc8_D=RESET_PC+8, valid_D=0, adel_D=0.
  - imem_req=1 in the first cycle after release.
- Misalignment: mis = (pc[1:0]!=0).
  - imem_req=!mis.
  - Effective ready: rdy = imem_ready | mis.
- Advance: adv = rdy & !stall_D.
- FSM, 2 states:
  - RUN goes to WAIT when imem_req & !imem_ready.
  - WAIT goes to RUN when imem_ready.
  - exc_req forces RUN.
  - The state is observable only through timing. The PC is stable for as long as the FSM is in WAIT, unless exc_req arrives.
- Next-PC priority, evaluated at each edge:
  1. exc_req: pc<=EXC_VECTOR, pend_v<=0, valid_D<=0. This ignores stall_D and imem_ready and abandons the in-flight fetch.
  2. adv & pend_v: pc<=pend_pc, pend_v<=0.
  3. adv & redirect_v: pc<=redirect_pc.
  4. adv: pc<=npc_F.
  5. otherwise: pc holds.
- Pending redirect:
  - If redirect_v arrives and adv==0, latch pend_v<=1 and pend_pc<=redirect_pc.
  - A later redirect_v overwrites pend_pc.
  - This guarantees the delay slot (the word currently being fetched) is never lost.
- IF/ID register:
  - On adv: instr_D<=mis?32'h0:imem_rdata, pc_D<=pc, pc8_D<=pc+8 (mod 2^32), adel_D<=mis, valid_D<=!flush_D.
  - On !stall_D & !rdy: valid_D<=0 and adel_D<=0 (bubble); the other fields hold.
  - On stall_D: everything holds, except exc_req or flush_D clears valid_D.
- Simultaneous events:
  - exc_req beats everything.
  - flush_D alone does not change the PC.
  - Reset mid-WAIT drops the outstanding fetch; the memory must tolerate an address change.
- Wrap: pc 32'hFFFF_FFFC plus 4 wraps to 0; pc8_D wraps the same way.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_fetch_cnt[31:0] (increments on every adv that loads valid_D=1).
  - Adds perf_miss_cnt[31:0] (increments on every cycle in WAIT).
  - Both reset to 0 and wrap at 2^32.
- Undefined: the ports and counters are absent, and the behaviour is otherwise identical.

Decomposition:
- Package fetch_pkg:
  - RESET_PC_DEF, EXC_VECTOR_DEF, NOP_INSTR=32'h0.
  - fetch_state_t {RUN, WAIT}.
- One sub-module, if_id_reg: IF/ID fields with load/hold/bubble/clear controls.
- The PC, pend and FSM logic stay in fetch_pc_unit.

Test Plan:
1. Release reset, imem_ready=1 constant, no stalls -> pc 3000, 3004, 3008; pc_D=3000 with pc8_D=3008 and valid_D=1 one cycle after each pc.
2. imem_ready low for 3 cycles at pc=3008 -> pc holds 3008 for 4 cycles, valid_D=0 for 3 cycles, then instr for 3008 enters ID.
3. redirect_v with redirect_pc=3100 while the delay slot at 300C waits on memory -> pend_v set, 300C reaches ID, next pc=3100.
4. exc_req during stall_D=1 and WAIT -> next pc=4180 and valid_D=0; the pending redirect is discarded.
5. redirect_pc=3102 -> the following cycle has imem_req=0; the next ID entry has adel_D=1, instr_D=0, pc_D=3102.
6. Assert reset while in WAIT -> pc=3000 and valid_D=0 immediately; with FETCH_PERF_CNT_EN defined, both counters are 0.
